// File: rtl/tx_result_packer_if.sv
// Bundle of the tile-request, lane-snapshot and TX-FIFO write signals of tx_result_packer.
// The master side is the compute/FIFO environment and the slave side is the packer.
interface tx_result_packer_if #(
  parameter int NUM_LANES          = 64,
  parameter int COMPUTE_DATA_WIDTH = 4,
  parameter int FIFO_DATA_WIDTH    = 8
);
  logic                          start;
  logic [COMPUTE_DATA_WIDTH-1:0] lanes_in [NUM_LANES];
  logic                          fifo_full;
  logic                          fifo_we;
  logic [FIFO_DATA_WIDTH-1:0]    fifo_w_data;
  logic                          busy;
  logic                          done;

  modport master (
    output start, lanes_in, fifo_full,
    input  fifo_we, fifo_w_data, busy, done
  );

  modport slave (
    input  start, lanes_in, fifo_full,
    output fifo_we, fifo_w_data, busy, done
  );
endinterface

// File: rtl/tx_result_packer.sv
// Snapshots one tile of result lanes and streams it to the TX FIFO as
// optional header, packed payload bytes (lowest lane in the LSBs) and an XOR checksum.
module tx_result_packer #(
  parameter int             NUM_LANES          = 64,
  parameter int             COMPUTE_DATA_WIDTH = 4,
  parameter int             FIFO_DATA_WIDTH    = 8,
  parameter bit             HEADER_EN          = 1'b1,
  parameter logic [7:0]     HEADER_BYTE        = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  tx_result_packer_if.slave bus
);

  localparam int LANES_PER_BYTE = FIFO_DATA_WIDTH / COMPUTE_DATA_WIDTH;
  localparam int NUM_BYTES      = NUM_LANES / LANES_PER_BYTE;
  localparam int FLAT_W         = NUM_LANES * COMPUTE_DATA_WIDTH;
  localparam int CNT_W          = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HEADER   = 3'd1;
  localparam logic [2:0] ST_PAYLOAD  = 3'd2;
  localparam logic [2:0] ST_CHECKSUM = 3'd3;
  localparam logic [2:0] ST_FINISH   = 3'd4;

  logic [2:0]                 state_r;
  logic [2:0]                 state_next_s;
  logic [FLAT_W-1:0]          snap_r;
  logic [FLAT_W-1:0]          lanes_flat_s;
  logic [CNT_W-1:0]           cnt_r;
  logic [FIFO_DATA_WIDTH-1:0] csum_r;
  logic [FIFO_DATA_WIDTH-1:0] payload_s;
  logic [FIFO_DATA_WIDTH-1:0] w_data_s;
  logic                       active_s;
  logic                       write_s;

  // Byte idx of the flattened tile; lane i sits at bits [i*W +: W], so bytes are contiguous.
  function automatic logic [FIFO_DATA_WIDTH-1:0] tile_byte(
    input logic [FLAT_W-1:0] flat,
    input logic [CNT_W-1:0]  idx
  );
    tile_byte = flat[{idx, 3'b000} +: FIFO_DATA_WIDTH];
  endfunction

  function automatic logic [FIFO_DATA_WIDTH-1:0] csum_next(
    input logic [FIFO_DATA_WIDTH-1:0] acc,
    input logic [FIFO_DATA_WIDTH-1:0] data
  );
    csum_next = acc ^ data;
  endfunction

  // Flatten the incoming lane array so payload bytes can be sliced directly.
  always_comb begin
    lanes_flat_s = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lanes_flat_s[i*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH] = bus.lanes_in[i];
    end
  end

  // Write strobe: a byte leaves whenever an emitting state sees room in the FIFO.
  always_comb begin
    if ((state_r == ST_HEADER) || (state_r == ST_PAYLOAD) || (state_r == ST_CHECKSUM)) begin
      active_s = 1'b1;
    end else begin
      active_s = 1'b0;
    end
    write_s   = active_s & ~bus.fifo_full;
    payload_s = tile_byte(snap_r, cnt_r);
  end

  // Next-state decode; every emitting state holds until its byte is consumed.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_next_s = HEADER_EN ? ST_HEADER : ST_PAYLOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (write_s) begin
          state_next_s = ST_PAYLOAD;
        end else begin
          state_next_s = ST_HEADER;
        end
      end
      ST_PAYLOAD: begin
        if (write_s && (cnt_r == LAST_IDX)) begin
          state_next_s = ST_CHECKSUM;
        end else begin
          state_next_s = ST_PAYLOAD;
        end
      end
      ST_CHECKSUM: begin
        if (write_s) begin
          state_next_s = ST_FINISH;
        end else begin
          state_next_s = ST_CHECKSUM;
        end
      end
      ST_FINISH: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Snapshot, byte counter and checksum; the counter stops at the last byte instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_r <= '0;
      cnt_r  <= '0;
      csum_r <= '0;
    end else if ((state_r == ST_IDLE) && bus.start) begin
      snap_r <= lanes_flat_s;
      cnt_r  <= '0;
      csum_r <= '0;
    end else if ((state_r == ST_PAYLOAD) && write_s) begin
      csum_r <= csum_next(csum_r, payload_s);
      if (cnt_r != LAST_IDX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Byte mux: the bus stays at zero outside the emitting states.
  always_comb begin
    case (state_r)
      ST_HEADER:   w_data_s = HEADER_BYTE;
      ST_PAYLOAD:  w_data_s = payload_s;
      ST_CHECKSUM: w_data_s = csum_r;
      default:     w_data_s = {FIFO_DATA_WIDTH{1'b0}};
    endcase
  end

  assign bus.fifo_we     = write_s;
  assign bus.fifo_w_data = w_data_s;
  assign bus.busy        = (state_r != ST_IDLE);
  assign bus.done        = (state_r == ST_FINISH);

endmodule

// File: tb/tb_tx_result_packer.sv
// Scoreboard bench for tx_result_packer: directed tiles push expected bytes and done
// cycles into queues; a negedge monitor pops and compares whatever the DUTs emit.
module tb_tx_result_packer;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   we_cnt0 = 0;
  int   start_cyc = 0;

  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  int         done0 [$];
  int         done1 [$];

  logic [7:0] pat [8] = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};

  tx_result_packer_if #(.NUM_LANES(64), .COMPUTE_DATA_WIDTH(4), .FIFO_DATA_WIDTH(8)) bus0 ();
  tx_result_packer_if #(.NUM_LANES(64), .COMPUTE_DATA_WIDTH(4), .FIFO_DATA_WIDTH(8)) bus1 ();

  tx_result_packer #(
    .NUM_LANES(64), .COMPUTE_DATA_WIDTH(4), .FIFO_DATA_WIDTH(8),
    .HEADER_EN(1'b1), .HEADER_BYTE(8'hA5)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  tx_result_packer #(
    .NUM_LANES(64), .COMPUTE_DATA_WIDTH(4), .FIFO_DATA_WIDTH(8),
    .HEADER_EN(1'b0), .HEADER_BYTE(8'hA5)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_byte(input int which, input logic [7:0] b);
    if (which == 0) exp0.push_back(b);
    else            exp1.push_back(b);
  endtask

  // kind 0: lane i = i mod 16 (checksum 00); kind 1: only lane 0 = 1 (checksum 01)
  task automatic push_pkt(input int which, input int kind, input bit hdr);
    if (hdr) push_byte(which, 8'hA5);
    for (int k = 0; k < 32; k++) begin
      if (kind == 0) push_byte(which, pat[k % 8]);
      else           push_byte(which, (k == 0) ? 8'h01 : 8'h00);
    end
    push_byte(which, (kind == 0) ? 8'h00 : 8'h01);
  endtask

  // kind 0: pattern, 1: single lane, 2: all 0xF
  task automatic set_lanes(input int which, input int kind);
    for (int i = 0; i < 64; i++) begin
      logic [3:0] v;
      if (kind == 0)      v = 4'(i % 16);
      else if (kind == 1) v = (i == 0) ? 4'h1 : 4'h0;
      else                v = 4'hF;
      if (which == 0) bus0.lanes_in[i] = v;
      else            bus1.lanes_in[i] = v;
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int which);
    @(posedge clk);
    #1;
    if (which == 0) bus0.start = 1'b1;
    else            bus1.start = 1'b1;
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    start_cyc  = cyc;
  endtask

  task automatic wait_done(input int which, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = (which == 0) ? bus0.done : bus1.done;
    end
    if (!seen) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL %s: done never seen, expected within 200 cycles", name);
    end
  endtask

  // Scoreboard monitor: every written byte and every done pulse must match the queues.
  initial forever begin
    @(negedge clk);
    if (bus0.fifo_we) begin
      we_cnt0 = we_cnt0 + 1;
      check("dut0_we_while_full", 32'(bus0.fifo_full), 32'd0);
      if (exp0.size() == 0) begin
        checks = checks + 1; failures = failures + 1;
        $display("FAIL dut0_extra_byte: got %02h expected no write", bus0.fifo_w_data);
      end else begin
        check("dut0_byte", 32'(bus0.fifo_w_data), 32'(exp0.pop_front()));
      end
    end
    if (bus0.done) begin
      if (done0.size() == 0) begin
        checks = checks + 1; failures = failures + 1;
        $display("FAIL dut0_extra_done: got done at cycle %0d expected none", cyc);
      end else begin
        check("dut0_done_cycle", 32'(cyc), 32'(done0.pop_front()));
      end
    end
    if (bus1.fifo_we) begin
      if (exp1.size() == 0) begin
        checks = checks + 1; failures = failures + 1;
        $display("FAIL dut1_extra_byte: got %02h expected no write", bus1.fifo_w_data);
      end else begin
        check("dut1_byte", 32'(bus1.fifo_w_data), 32'(exp1.pop_front()));
      end
    end
    if (bus1.done) begin
      if (done1.size() == 0) begin
        checks = checks + 1; failures = failures + 1;
        $display("FAIL dut1_extra_done: got done at cycle %0d expected none", cyc);
      end else begin
        check("dut1_done_cycle", 32'(cyc), 32'(done1.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1;
    bus0.start = 1'b0; bus0.fifo_full = 1'b0;
    bus1.start = 1'b0; bus1.fifo_full = 1'b0;
    set_lanes(0, 0);
    set_lanes(1, 0);
    wait_edges(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_we",   32'(bus0.fifo_we),     32'd0);
    check("reset_data", 32'(bus0.fifo_w_data), 32'd0);
    check("reset_busy", 32'(bus0.busy),        32'd0);
    check("reset_done", 32'(bus0.done),        32'd0);
    check("reset_we1",  32'(bus1.fifo_we),     32'd0);

    // Pattern stream: A5, 10 32 .. FE x4, 00; done after edge 34 (35th cycle)
    push_pkt(0, 0, 1'b1);
    base = we_cnt0;
    pulse_start(0);
    done0.push_back(start_cyc + 34);
    wait_done(0, "pattern_done");
    check("pattern_we_count", 32'(we_cnt0 - base), 32'd34);
    check("finish_busy",      32'(bus0.busy),      32'd1);

    // Single lane, started in the IDLE cycle right after FINISH
    set_lanes(0, 1);
    push_pkt(0, 1, 1'b1);
    pulse_start(0);
    done0.push_back(start_cyc + 34);
    wait_done(0, "single_done");
    set_lanes(0, 0);

    // Back-pressure: 2 stalls in HEADER, 3 at payload byte 5 -> done 5 cycles late
    push_pkt(0, 0, 1'b1);
    pulse_start(0);
    done0.push_back(start_cyc + 39);
    bus0.fifo_full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("hdr_stall_we",   32'(bus0.fifo_we),     32'd0);
      check("hdr_stall_data", 32'(bus0.fifo_w_data), 32'hA5);
      @(posedge clk);
      #1;
    end
    bus0.fifo_full = 1'b0;
    wait_edges(6);
    bus0.fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b5_stall_we",   32'(bus0.fifo_we),     32'd0);
      check("b5_stall_data", 32'(bus0.fifo_w_data), 32'hBA);
      @(posedge clk);
      #1;
    end
    bus0.fifo_full = 1'b0;
    wait_done(0, "stall_done");

    // Snapshot isolation plus starts during PAYLOAD and FINISH
    push_pkt(0, 0, 1'b1);
    pulse_start(0);
    done0.push_back(start_cyc + 34);
    set_lanes(0, 2);
    wait_edges(9);
    bus0.start = 1'b1;
    wait_edges(1);
    bus0.start = 1'b0;
    wait_edges(24);
    check("finish_done_level", 32'(bus0.done), 32'd1);
    bus0.start = 1'b1;
    wait_edges(1);
    bus0.start = 1'b0;
    @(negedge clk);
    check("finish_start_ignored", 32'(bus0.busy), 32'd0);
    set_lanes(0, 0);

    // Mid-packet reset while payload byte 10 is on the bus
    push_byte(0, 8'hA5);
    for (int k = 0; k <= 10; k++) push_byte(0, pat[k % 8]);
    pulse_start(0);
    wait_edges(11);
    rst = 1'b1;
    wait_edges(1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_we",    32'(bus0.fifo_we), 32'd0);
    check("abort_busy",  32'(bus0.busy),    32'd0);
    check("abort_drain", 32'(exp0.size()),  32'd0);
    push_pkt(0, 0, 1'b1);
    pulse_start(0);
    done0.push_back(start_cyc + 34);
    wait_done(0, "after_abort_done");

    // Headerless instance: 33 bytes, done after edge 33 (34th cycle)
    push_pkt(1, 0, 1'b0);
    pulse_start(1);
    done1.push_back(start_cyc + 33);
    wait_done(1, "nohdr_done");

    wait_edges(3);
    check("dut0_bytes_left", 32'(exp0.size()),  32'd0);
    check("dut1_bytes_left", 32'(exp1.size()),  32'd0);
    check("dut0_done_left",  32'(done0.size()), 32'd0);
    check("dut1_done_left",  32'(done1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_result_packer.md
# tx_result_packer

Serializes one tile of 4-bit result lanes, the post-quantizer/ReLU outputs of the 8x8 array, into a framed byte stream for the transmit FIFO that feeds the UART. It sits between the compute result path and `fifo_tx`. On a `start` pulse it snapshots all lanes and emits:

- an optional header byte,
- the packed payload bytes,
- an XOR checksum byte,

honouring FIFO back-pressure, then pulses `done`.

## Interface

Parameters:
- `NUM_LANES`, 64, number of result lanes per tile
- `COMPUTE_DATA_WIDTH`, 4, bits per lane; must divide 8
- `FIFO_DATA_WIDTH`, 8, FIFO byte width; fixed at 8
- `HEADER_EN`, 1, 1 = emit header byte before payload
- `HEADER_BYTE`, 8'hA5, header value
- Derived: `LANES_PER_BYTE` = 8/`COMPUTE_DATA_WIDTH`; `NUM_BYTES` = `NUM_LANES`/`LANES_PER_BYTE`. `NUM_LANES`·`COMPUTE_DATA_WIDTH` must be a multiple of 8.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  single-cycle request to send one tile
- `lanes_in`  in  `NUM_LANES` x `COMPUTE_DATA_WIDTH`  unpacked array of result lanes; sampled only on an accepted start
- `fifo_full`  in  1  TX FIFO full flag
- `fifo_we`  out  1  TX FIFO write enable
- `fifo_w_data`  out  8  byte presented to the TX FIFO
- `busy`  out  1  high from the cycle after an accepted start until `done`, inclusive
- `done`  out  1  one-cycle pulse after the checksum byte is written

## Operation

- FSM states: IDLE, HEADER, PAYLOAD, CHECKSUM, FINISH.
- **IDLE:**
  - `start`=1 copies `lanes_in` into an internal snapshot register.
  - Clears the checksum accumulator and byte counter.
  - Goes to HEADER if `HEADER_EN`, else PAYLOAD.
- **Write rule** (HEADER, PAYLOAD, CHECKSUM):
  - `fifo_we` = state active && !`fifo_full`. This is combinational from the state register and `fifo_full`.
  - The byte is consumed on the clock edge where `fifo_we`=1. Otherwise the state, counter and data hold.
- **HEADER:** `fifo_w_data` = `HEADER_BYTE`. On write, go to PAYLOAD.
- **PAYLOAD:**
  - Byte k: lane (k·`LANES_PER_BYTE`+j) occupies bits [j·`COMPUTE_DATA_WIDTH` +: `COMPUTE_DATA_WIDTH`], so the lowest lane index sits in the LSBs.
  - For the default config, byte k = {lane[2k+1], lane[2k]}.
  - On each write, checksum ^= byte and k increments. After byte `NUM_BYTES`-1 is written, go to CHECKSUM.
- **CHECKSUM:** `fifo_w_data` = XOR of all payload bytes; the header is excluded. On write, go to FINISH.
- **FINISH:** `done`=1 for this one cycle, `busy`=1, then unconditionally to IDLE.
- `start` outside IDLE (including FINISH) is ignored and is not queued.
- Changes on `lanes_in` after acceptance do not affect the packet.
- `fifo_w_data` is 0 in IDLE and FINISH.

## Timing

- Reset values:
  - state IDLE, `fifo_we`=0, `fifo_w_data`=0, `busy`=0, `done`=0
  - counter 0, checksum 0, snapshot 0
- `rst` mid-packet aborts immediately. The cycle after `rst`, state is IDLE and `fifo_we`=0. Bytes already written stay in the FIFO; no flush and no trailer are sent.
- Latency with `fifo_full` always 0 and `start` sampled at edge 0 (defaults):
  - header written at edge 1
  - payload at edges 2..33
  - checksum at edge 34
  - `done` high during the cycle after edge 34; IDLE after edge 35
- Total bytes = `NUM_BYTES` + 1 + `HEADER_EN`; 34 for defaults.
- Each cycle `fifo_full`=1 in an active state adds exactly one cycle of latency. No byte is dropped or duplicated.
- Throughput: one byte per cycle maximum. Back-to-back tiles have a 2-cycle gap: FINISH, then IDLE accepting `start`.
- Counter width `$clog2(NUM_BYTES)`. Terminal compare is `NUM_BYTES`-1, with no wrap beyond it.

## Test plan

- **Pattern stream:** lane i = i mod 16, `fifo_full`=0. Expect:
  - bytes A5, then 10 32 54 76 98 BA DC FE repeated 4x, then checksum 00
  - `fifo_we` high exactly 34 cycles
  - `done` one cycle, 35 cycles after start
- **Single lane:** lane 0 = 1, all others 0. Expect payload 01 followed by 31x 00, then checksum 01.
- **Back-pressure:**
  - Hold `fifo_full`=1 for 3 cycles at payload byte 5: `fifo_we`=0 throughout and byte 5 is unchanged.
  - Hold `fifo_full`=1 during HEADER for 2 cycles.
  - Expect `done` 5 cycles late with an identical byte sequence.
- **Snapshot and ignored starts:**
  - Change `lanes_in` to all 0xF the cycle after start: the packet still carries the original values.
  - Pulse `start` during PAYLOAD and during FINISH: neither produces a second packet.
  - A `start` in the cycle after FINISH yields a new packet.
- **Mid-packet reset:** assert `rst` at payload byte 10. Expect `fifo_we`=0 and `busy`=0 the next cycle. A following start emits a full 34-byte packet beginning with A5.
- **`HEADER_EN`=0:** expect 33 bytes, the first being payload byte 0, and `done` 34 cycles after start.
